// File: rtl/microseq_loader.sv
// Microcode sequencer: copies the EPROM image into control-store RAM after reset, then sequences microwords.
// Latency: load finishes DEPTH+1 cycles after reset release; in RUN, cs_addr advances one step per unstalled cycle.
// Backpressure: stall=1 holds cs_addr and the call stack. Optional parity check is enabled by MICROSEQ_PARITY_EN.
module microseq_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WORD_WIDTH  = 64,
    parameter int NEXT_LSB    = 25,
    parameter int SEQOP_LSB   = 46,
    parameter int COND_LSB    = 48,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = 8'hFE
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    input  logic [ADDR_WIDTH-1:0] ir,
    input  logic [3:0]            cond,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic [WORD_WIDTH-1:0] cs_word,
    output logic                  cs_ready,
    output logic                  halted,
    output logic                  stack_err,
    output logic                  parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST    = '1;
    localparam logic [SP_W-1:0]       SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    localparam logic [1:0] OP_GOTO   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_CALL   = 2'b10;
    localparam logic [1:0] OP_RETURN = 2'b11;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [ADDR_WIDTH-1:0] r_ld_addr;
    logic                  r_ld_vld;
    logic [WORD_WIDTH-1:0] r_ram [DEPTH];
    logic [ADDR_WIDTH-1:0] r_cs_addr;
    // Sized to a power of two so the pointer can index it without range gaps.
    logic [ADDR_WIDTH-1:0] r_stack [1 << SP_W];
    logic [SP_W-1:0]       r_sp;
    logic                  r_stack_err;

    logic [WORD_WIDTH-1:0] w_cs_word;
    logic [ADDR_WIDTH-1:0] w_n;
    logic [1:0]            w_op;
    logic [1:0]            w_c;
    logic [ADDR_WIDTH-1:0] w_inc;
    logic [SP_W-1:0]       w_sp_m1;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_stk_err_set;

    assign w_cs_word = (r_state == S_LOAD) ? '0 : r_ram[r_cs_addr];
    assign w_n       = w_cs_word[NEXT_LSB +: ADDR_WIDTH];
    assign w_op      = w_cs_word[SEQOP_LSB +: 2];
    assign w_c       = w_cs_word[COND_LSB +: 2];
    assign w_inc     = r_cs_addr + 1'b1;
    assign w_sp_m1   = r_sp - 1'b1;

`ifdef MICROSEQ_PARITY_EN
    logic r_parity_err;
    logic w_par_err_set;
`endif

    // State register: every reset restarts a full image load.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_state_nxt;
    end

    // Next state, next microaddress and stack/error controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_cs_addr;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_stk_err_set = 1'b0;
`ifdef MICROSEQ_PARITY_EN
        w_par_err_set = 1'b0;
`endif
        case (r_state)
            S_LOAD: begin
                if (r_ld_vld && (r_ld_addr == LAST)) begin
                    w_state_nxt = S_RUN;
                    w_addr_nxt  = '0;
                end
            end
            S_RUN: begin
                // Halt address wins over stall and over the word's own op.
                if (r_cs_addr == HALT_ADDR) begin
                    w_state_nxt = S_HALT;
                end else if (!stall) begin
`ifdef MICROSEQ_PARITY_EN
                    if (^w_cs_word) begin
                        w_par_err_set = 1'b1;
                        w_state_nxt   = S_HALT;
                    end else begin
`else
                    begin
`endif
                        case (w_op)
                            OP_GOTO:   w_addr_nxt = (w_n == '0) ? ir : w_n;
                            OP_BRANCH: w_addr_nxt = cond[w_c] ? w_n : w_inc;
                            OP_CALL: begin
                                w_addr_nxt = w_n;
                                if (r_sp == SP_FULL) w_stk_err_set = 1'b1;
                                else                 w_push        = 1'b1;
                            end
                            default: begin
                                if (r_sp == '0) begin
                                    w_addr_nxt    = '0;
                                    w_stk_err_set = 1'b1;
                                end else begin
                                    w_addr_nxt = r_stack[w_sp_m1];
                                    w_pop      = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Load address generator; rom_data lags rom_addr by one cycle, so the write address is delayed to match.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_ld_addr  <= '0;
            r_ld_vld   <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (r_rom_addr != LAST) r_rom_addr <= r_rom_addr + 1'b1;
            r_ld_addr <= r_rom_addr;
            r_ld_vld  <= 1'b1;
        end
    end

    // Control-store write port, active only while loading.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_LOAD) && r_ld_vld) r_ram[r_ld_addr] <= rom_data;
    end

    // Microaddress, stack pointer and sticky stack error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_addr   <= '0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_cs_addr <= w_addr_nxt;
            if (w_push)        r_sp        <= r_sp + 1'b1;
            else if (w_pop)    r_sp        <= w_sp_m1;
            if (w_stk_err_set) r_stack_err <= 1'b1;
        end
    end

    // Return-address storage; contents need no reset because the pointer gates all reads.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_stack[r_sp] <= w_inc;
    end

`ifdef MICROSEQ_PARITY_EN
    // Sticky parity error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)              r_parity_err <= 1'b0;
        else if (w_par_err_set) r_parity_err <= 1'b1;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rom_addr  = r_rom_addr;
    assign cs_addr   = r_cs_addr;
    assign cs_word   = w_cs_word;
    assign cs_ready  = (r_state != S_LOAD);
    assign halted    = (r_state == S_HALT);
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_microseq_loader.sv
// Bench for microseq_loader: directed scenarios plus random programs against a queue-based reference model.
// Latency: load is expected 257 cycles after reset release; one microaddress step per unstalled cycle.
// Backpressure: stall is driven both in directed steps and randomly.
module tb_microseq_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [63:0] rom_data;
    logic [7:0]  ir;
    logic [3:0]  cond;
    logic        stall;
    logic [7:0]  cs_addr;
    logic [63:0] cs_word;
    logic        cs_ready, halted, stack_err, parity_err;

    always #5 clk = ~clk;

    microseq_loader dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .cond(cond), .stall(stall), .cs_addr(cs_addr), .cs_word(cs_word),
        .cs_ready(cs_ready), .halted(halted), .stack_err(stack_err), .parity_err(parity_err)
    );

    // EPROM model: data appears one cycle after the address.
    logic [63:0] rom_img [256];
    always @(posedge clk) rom_data <= rom_img[rom_addr];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    int m_addr;
    bit m_halted, m_err, m_perr;
    int m_stk[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkw(input int op, input int c, input int n);
        logic [63:0] w;
        w = '0;
        w[49:48] = c[1:0];
        w[47:46] = op[1:0];
        w[32:25] = n[7:0];
        w[63]    = ^w[62:0];
        return w;
    endfunction

    task automatic model_step(input logic [7:0] i_ir, input logic [3:0] i_cond, input logic i_stall);
        logic [63:0] w;
        int n, op, c;
        if (!m_halted) begin
            if (m_addr == 'hFE) begin
                m_halted = 1;
            end else if (!i_stall) begin
                w  = rom_img[m_addr];
                n  = int'(w[32:25]);
                op = int'(w[47:46]);
                c  = int'(w[49:48]);
`ifdef MICROSEQ_PARITY_EN
                if (^w) begin
                    m_perr   = 1;
                    m_halted = 1;
                end else
`endif
                begin
                    case (op)
                        0: m_addr = (n == 0) ? int'(i_ir) : n;
                        1: m_addr = i_cond[c] ? n : (m_addr + 1) % 256;
                        2: begin
                            if (m_stk.size() < 4) m_stk.push_back((m_addr + 1) % 256);
                            else                  m_err = 1;
                            m_addr = n;
                        end
                        default: begin
                            if (m_stk.size() == 0) begin
                                m_err  = 1;
                                m_addr = 0;
                            end else begin
                                m_addr = m_stk.pop_back();
                            end
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic cmp_all();
        logic [7:0] ma;
        ma = m_addr[7:0];
        chk("cs_addr", cs_addr, ma);
        chk("cs_word", cs_word, rom_img[ma]);
        chk("cs_ready", cs_ready, 1);
        chk("halted", halted, m_halted);
        chk("stack_err", stack_err, m_err);
        chk("parity_err", parity_err, m_perr);
    endtask

    task automatic run(input logic [7:0] i_ir, input logic [3:0] i_cond, input logic i_stall);
        ir    = i_ir;
        cond  = i_cond;
        stall = i_stall;
        @(posedge clk);
        model_step(i_ir, i_cond, i_stall);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic run_rand();
        run(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    endtask

    task automatic do_reset_load(input bit glitch);
        int cnt;
        reset = 1'b1;
        stall = 1'b0;
        ir    = '0;
        cond  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_cs_addr", cs_addr, 0);
        chk("rst_cs_ready", cs_ready, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stack_err", stack_err, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_cs_word", cs_word, 0);
        reset = 1'b0;
        if (glitch) begin
            repeat (100) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == 128) begin
                chk("load_not_ready", cs_ready, 0);
                chk("load_cs_word", cs_word, 0);
            end
        end while (!cs_ready && cnt < 400);
        chk("load_cycles", cnt, 257);
        chk("load_rom_addr_hold", rom_addr, 8'hFF);
        m_addr   = 0;
        m_halted = 0;
        m_err    = 0;
        m_perr   = 0;
        m_stk.delete();
        cmp_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Pattern image: each word is its address replicated across all bytes.
        for (int a = 0; a < 256; a++) rom_img[a] = {8{8'(a)}};
        do_reset_load(1'b0);
        run(8'h10, 4'h0, 1'b0);
        chk("pattern_addr", cs_addr, 8'h10);
        chk("pattern_word", cs_word, 64'h1010101010101010);
        repeat (50) run_rand();

        // Directed program: default word is GOTO addr+1.
        for (int a = 0; a < 256; a++) rom_img[a] = mkw(0, 0, (a + 1) % 256);
        rom_img[8'h00] = mkw(0, 0, 0);
        rom_img[8'h42] = mkw(0, 0, 8'h05);
        rom_img[8'h05] = mkw(0, 0, 8'h20);
        rom_img[8'h20] = mkw(1, 2, 8'h80);
        rom_img[8'h80] = mkw(0, 0, 8'h20);
        rom_img[8'h21] = mkw(0, 0, 8'hFF);
        rom_img[8'hFF] = mkw(1, 2, 8'h80);
        rom_img[8'h31] = mkw(2, 0, 8'h50);
        rom_img[8'h50] = mkw(2, 0, 8'h60);
        rom_img[8'h60] = mkw(2, 0, 8'h70);
        rom_img[8'h70] = mkw(2, 0, 8'h90);
        rom_img[8'h90] = mkw(3, 0, 0);
        rom_img[8'h71] = mkw(3, 0, 0);
        rom_img[8'h61] = mkw(3, 0, 0);
        rom_img[8'h51] = mkw(3, 0, 0);
        rom_img[8'h32] = mkw(2, 0, 8'hB0);
        rom_img[8'hB0] = mkw(2, 0, 8'hB8);
        rom_img[8'hB8] = mkw(2, 0, 8'hC0);
        rom_img[8'hC0] = mkw(2, 0, 8'hC8);
        rom_img[8'hC8] = mkw(2, 0, 8'hD0);
        rom_img[8'hD0] = mkw(3, 0, 0);
        rom_img[8'hC1] = mkw(3, 0, 0);
        rom_img[8'hB9] = mkw(3, 0, 0);
        rom_img[8'hB1] = mkw(3, 0, 0);
        rom_img[8'h33] = mkw(3, 0, 0);
        rom_img[8'h12] = rom_img[8'h12] ^ 64'h1;
        do_reset_load(1'b0);

        run(8'h42, 4'h0, 1'b0);    chk("dispatch_ir", cs_addr, 8'h42);
        run(8'h99, 4'h0, 1'b0);    chk("goto_n", cs_addr, 8'h05);
        run(8'h00, 4'h0, 1'b0);    chk("goto_20", cs_addr, 8'h20);
        run(8'h00, 4'b0100, 1'b0); chk("branch_taken", cs_addr, 8'h80);
        run(8'h00, 4'h0, 1'b0);
        run(8'h00, 4'h0, 1'b0);    chk("branch_fall", cs_addr, 8'h21);
        run(8'h00, 4'h0, 1'b0);
        run(8'h00, 4'b1011, 1'b0); chk("branch_wrap", cs_addr, 8'h00);
        run(8'h30, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run(8'h00, 4'hF, 1'b1); chk("stall_hold", cs_addr, 8'h30);
        end
        run(8'h00, 4'h0, 1'b0);    // 0x31
        run(8'h00, 4'h0, 1'b0);    // CALL -> 0x50
        run(8'h00, 4'h0, 1'b0);    // CALL -> 0x60
        run(8'h00, 4'h0, 1'b0);    // CALL -> 0x70
        run(8'h00, 4'h0, 1'b1);
        run(8'h00, 4'h0, 1'b1);    chk("stall_in_call", cs_addr, 8'h70);
        run(8'h00, 4'h0, 1'b0);    chk("call4", cs_addr, 8'h90);
        run(8'h00, 4'h0, 1'b0);    chk("ret1", cs_addr, 8'h71);
        run(8'h00, 4'h0, 1'b0);    chk("ret2", cs_addr, 8'h61);
        run(8'h00, 4'h0, 1'b0);    chk("ret3", cs_addr, 8'h51);
        run(8'h00, 4'h0, 1'b0);    chk("ret4", cs_addr, 8'h32);
        chk("no_err_4deep", stack_err, 0);
        repeat (4) run(8'h00, 4'h0, 1'b0);
        run(8'h00, 4'h0, 1'b0);    chk("call5_jump", cs_addr, 8'hD0);
        chk("call5_err", stack_err, 1);
        repeat (4) run(8'h00, 4'h0, 1'b0);
        chk("ret_after_ovf", cs_addr, 8'h33);
        run(8'h00, 4'h0, 1'b0);    chk("ret_empty", cs_addr, 8'h00);
        run(8'hF0, 4'h0, 1'b0);
        repeat (14) run(8'h00, 4'h0, 1'b0);
        chk("reach_fe", cs_addr, 8'hFE);
        chk("not_halted_yet", halted, 0);
        run(8'h00, 4'h0, 1'b1);    chk("halt_flag", halted, 1);
        repeat (3) run(8'h00, 4'h0, 1'b0);
        chk("halt_frozen", cs_addr, 8'hFE);
        chk("halt_ready", cs_ready, 1);

        // Reset while halted reloads, then the corrupted word at 0x12 is visited.
        do_reset_load(1'b0);
        run(8'h12, 4'h0, 1'b0);    chk("par_dispatch", cs_addr, 8'h12);
        run(8'h00, 4'h0, 1'b0);
`ifdef MICROSEQ_PARITY_EN
        chk("par_err_set", parity_err, 1);
        chk("par_halted", halted, 1);
        chk("par_addr_held", cs_addr, 8'h12);
`else
        chk("par_err_off", parity_err, 0);
        chk("par_off_halted", halted, 0);
        chk("par_off_advance", cs_addr, 8'h13);
`endif

        // Random programs with even-parity words.
        for (int img = 0; img < 6; img++) begin
            for (int a = 0; a < 256; a++) begin
                logic [63:0] w;
                w = {$urandom, $urandom};
                w[63] = ^w[62:0];
                rom_img[a] = w;
            end
            do_reset_load(img == 2);
            repeat (300) run_rand();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
